uart_rx_param: RTL and testbench
================================

// Module: uart_rx_param
// PURPOSE
//  Parametrised UART receiver; successor to the fixed 8-bit receiver. Adds configurable data width, 1/2 stop bits,
//  3-sample majority voting, input synchroniser and a valid/ready output FIFO carrying per-frame error flags.
//  Sits between the RX pin and the system-side register/command layer of the digital system.
// PARAMETERS
//  DATA_W      8  data bits per frame (5..9), LSB first on the line
//  PRESCALE_W  6  width of prescale input (oversampling ratio up to 2^PRESCALE_W-1)
//  FIFO_DEPTH  4  output FIFO entries (power of 2, >=2)
// PORTS
//  CLK         in   1           receiver clock (oversampling clock)
//  RST         in   1           synchronous, active-high reset
//  RX_IN       in   1           serial line, idle high, asynchronous to CLK
//  PAR_EN      in   1           1 = parity bit present after data
//  PAR_TYP     in   1           0 = even, 1 = odd
//  STOP2       in   1           1 = two stop bits expected
//  prescale    in   PRESCALE_W  CLK cycles per bit; values <8 treated as 8
//  P_DATA      out  DATA_W      FIFO head data
//  PAR_ERROR   out  1           FIFO head parity error flag (0 when PAR_EN was 0 for that frame)
//  STP_ERROR   out  1           FIFO head stop error flag
//  DATA_VALID  out  1           FIFO non-empty
//  DATA_READY  in   1           consumer accepts head when DATA_VALID & DATA_READY
//  OVERRUN     out  1           1-cycle pulse: completed frame dropped, FIFO full
//  BUSY        out  1           FSM not in IDLE
//  BRK_DET     out  1           1-cycle break pulse (tied 0 without UART_RX_BREAK_DET_EN)
// BEHAVIOUR
//  - Reset: all outputs 0; synchroniser flops, majority sampler = 1; FSM = IDLE; FIFO empty; counters 0.
//  - RX_IN passes a 2-flop synchroniser (reset 1); all decisions use rx_s; 2-cycle pin-to-FSM latency.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> [STOP_2] -> IDLE (enum in package).
//  - IDLE: falling edge of rx_s (prev 1, now 0) -> START; edge_cnt=1, bit_cnt=0. PAR_EN, PAR_TYP, STOP2,
//    prescale latched here; mid-frame changes ignored until next frame.
//  - edge_cnt counts 0..P-1 per bit (P = latched prescale, min 8); wraps to 0 and bit_cnt++ at P-1.
//  - Sampling: rx_s captured at edge_cnt = M-1, M, M+1 (M = P>>1); bit value = majority of 3, valid at M+1.
//  - START: sampled 1 -> glitch, back to IDLE, nothing pushed. Sampled 0 -> DATA at bit end.
//  - DATA: shift in DATA_W bits LSB first; after bit DATA_W-1 -> PARITY if PAR_EN else STOP.
//  - PARITY: par_err = sampled ^ (^data) ^ PAR_TYP.
//  - STOP: stp_err |= ~sampled. STOP2=1 -> STOP_2 at bit end, same check. On the LAST stop bit, at its sample
//    point (M+1): push {data,par_err,stp_err} and return to IDLE same cycle (half-bit resync margin,
//    back-to-back frames supported).
//  - Push when FIFO full: frame dropped, OVERRUN pulses that cycle, FIFO contents untouched.
//  - Push and pop in same cycle when full: pop first, push accepted, no OVERRUN.
//  - FIFO outputs combinational from head entry; pop on DATA_VALID & DATA_READY; empty pop ignored.
//  - BUSY = (state != IDLE). RST mid-frame: frame discarded, FIFO flushed, next cycle behaves as post-reset.
// CONFIGURATION
//  UART_RX_BREAK_DET_EN defined: if all data bits, parity (if any) and the first stop bit sample 0, frame is
//  NOT pushed; BRK_DET pulses 1 cycle at that stop sample; FSM waits in IDLE for rx_s=1 before accepting a new
//  start edge. Undefined: such a frame is pushed as normal data with STP_ERROR=1; BRK_DET tied 0.
// STRUCTURE
//  uart_rx_pkg: state enum (IDLE,START,DATA,PARITY,STOP,STOP_2), MIN_PRESCALE=8, FIFO entry struct
//  {data,par_err,stp_err}. One sub-module: uart_rx_fifo (sync FIFO, DEPTH/WIDTH params, full/empty, sync RST).
//  Synchroniser, counters, sampler and FSM stay in uart_rx_param.
// TESTING
//  1. DATA_W=8,P=8,no parity,1 stop, send 0xA5, READY=1 -> one entry 0xA5, both errors 0, valid 1 cycle.
//  2. PAR_EN=1,PAR_TYP=0, send 0x03 with parity bit 1 -> P_DATA=0x03, PAR_ERROR=1; with bit 0 -> PAR_ERROR=0.
//  3. STOP2=1, second stop bit driven 0, data 0x5A -> P_DATA=0x5A, STP_ERROR=1, PAR_ERROR=0.
//  4. 4-cycle low pulse on idle line, P=16 -> no push, BUSY high then low, FSM back in IDLE.
//  5. READY=0, send 5 frames 0x01..0x05, FIFO_DEPTH=4 -> OVERRUN pulses once (frame 5); drain gives 0x01..0x04.
//  6. Single-cycle spike inverting RX_IN at sample point M of a data bit -> majority keeps correct value;
//     RST asserted mid-frame -> DATA_VALID=0 next cycle, following clean 0x3C frame received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types for the parametrised UART receiver: FSM state, FIFO entry layout, sampling helpers.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    STOP_2
  } uart_rx_state_e;

  localparam int MIN_PRESCALE = 8;
  localparam int MAX_DATA_W   = 9;

  // Data field sized for the widest frame; narrower builds zero-fill the top bits.
  typedef struct packed {
    logic [MAX_DATA_W-1:0] data;
    logic                  par_err;
    logic                  stp_err;
  } uart_rx_entry_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO for received frames; a pop frees a slot for a push in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_wr;
  logic             do_rd;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_rd     = rd_en_i && !empty_o;
  assign do_wr     = wr_en_i && (!full_o || do_rd);
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchroniser, 3-sample majority, framing FSM and output FIFO.
// Optional break detection is compiled in with UART_RX_BREAK_DET_EN.
module uart_rx_param
  import uart_rx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [DATA_W-1:0]     P_DATA,
  output logic                  PAR_ERROR,
  output logic                  STP_ERROR,
  output logic                  DATA_VALID,
  input  logic                  DATA_READY,
  output logic                  OVERRUN,
  output logic                  BUSY,
  output logic                  BRK_DET,
  output uart_rx_state_e        state_o
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0]      LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [PRESCALE_W-1:0] MIN_P    = PRESCALE_W'(MIN_PRESCALE);
  localparam logic [PRESCALE_W-1:0] ONE      = PRESCALE_W'(1);

  uart_rx_state_e        state_q;
  logic                  rx_meta_q, rx_s_q, rx_prev_q;
  logic [PRESCALE_W-1:0] presc_q, edge_cnt_q, mid;
  logic [BIT_W-1:0]      bit_cnt_q;
  logic                  par_en_q, par_typ_q, stop2_q;
  logic [DATA_W-1:0]     data_q;
  logic                  par_err_q, stp_err_q, s0_q, s1_q;
`ifdef UART_RX_BREAK_DET_EN
  logic                  all_zero_q, wait_high_q;
`endif
  logic                  at_s0, at_s1, at_smp, bit_end, smp_bit, start_edge;
  logic                  last_stop, brk, push, pop, full, empty;
  uart_rx_entry_t        wr_entry, head;
  logic                  unused_head_bits;

  assign mid     = presc_q >> 1;
  assign at_s0   = (edge_cnt_q == mid - ONE);
  assign at_s1   = (edge_cnt_q == mid);
  assign at_smp  = (edge_cnt_q == mid + ONE);
  assign bit_end = (edge_cnt_q == presc_q - ONE);
  assign smp_bit = majority3(s0_q, s1_q, rx_s_q);
`ifdef UART_RX_BREAK_DET_EN
  assign start_edge = rx_prev_q && !rx_s_q && !wait_high_q;
`else
  assign start_edge = rx_prev_q && !rx_s_q;
`endif

  always_comb begin
    last_stop = at_smp && ((state_q == STOP && !stop2_q) || state_q == STOP_2);
    brk       = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    brk       = at_smp && (state_q == STOP) && all_zero_q && !smp_bit;
`endif
    push             = last_stop && !brk;
    wr_entry         = '0;
    wr_entry.data    = MAX_DATA_W'(data_q);
    wr_entry.par_err = par_err_q;
    wr_entry.stp_err = stp_err_q | ~smp_bit;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
      state_q    <= IDLE;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      presc_q    <= MIN_P;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      stop2_q    <= 1'b0;
      data_q     <= '0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      all_zero_q  <= 1'b0;
      wait_high_q <= 1'b0;
`endif
    end else begin
      rx_meta_q <= RX_IN;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      if (state_q != IDLE) begin
        edge_cnt_q <= bit_end ? '0 : edge_cnt_q + 1'b1;
        if (at_s0) s0_q <= rx_s_q;
        if (at_s1) s1_q <= rx_s_q;
      end
      unique case (state_q)
        IDLE: begin
`ifdef UART_RX_BREAK_DET_EN
          if (wait_high_q && rx_s_q) wait_high_q <= 1'b0;
          all_zero_q <= 1'b1;
`endif
          if (start_edge) begin
            state_q    <= START;
            edge_cnt_q <= ONE;
            bit_cnt_q  <= '0;
            presc_q    <= (prescale < MIN_P) ? MIN_P : prescale;
            par_en_q   <= PAR_EN;
            par_typ_q  <= PAR_TYP;
            stop2_q    <= STOP2;
            par_err_q  <= 1'b0;
            stp_err_q  <= 1'b0;
          end
        end
        START: begin
          if (at_smp && smp_bit) state_q <= IDLE;
          else if (bit_end)      state_q <= DATA;
        end
        DATA: begin
          if (at_smp) begin
            data_q <= {smp_bit, data_q[DATA_W-1:1]};
`ifdef UART_RX_BREAK_DET_EN
            all_zero_q <= all_zero_q & ~smp_bit;
`endif
          end
          if (bit_end) begin
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q <= '0;
              state_q   <= par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        PARITY: begin
          if (at_smp) begin
            par_err_q <= smp_bit ^ (^data_q) ^ par_typ_q;
`ifdef UART_RX_BREAK_DET_EN
            all_zero_q <= all_zero_q & ~smp_bit;
`endif
          end
          if (bit_end) state_q <= STOP;
        end
        STOP: begin
          // The last stop bit releases the FSM at its sample point so a following start edge is never missed.
          if (at_smp) begin
            if (brk) begin
              state_q <= IDLE;
`ifdef UART_RX_BREAK_DET_EN
              wait_high_q <= 1'b1;
`endif
            end else if (!stop2_q) begin
              state_q <= IDLE;
            end else begin
              stp_err_q <= stp_err_q | ~smp_bit;
            end
          end else if (bit_end) begin
            state_q <= STOP_2;
          end
        end
        STOP_2: begin
          if (at_smp) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output handshake: the head entry is held while DATA_VALID=1 and is consumed on a cycle where
  // DATA_VALID and DATA_READY are both 1; DATA_VALID never drops without such a transfer (except on RST).
  assign pop = DATA_VALID && DATA_READY;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(uart_rx_entry_t))
  ) u_fifo (
    .clk_i     (CLK),
    .rst_i     (RST),
    .wr_en_i   (push),
    .wr_data_i (wr_entry),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .full_o    (full),
    .empty_o   (empty)
  );

  assign DATA_VALID       = !empty;
  assign P_DATA           = empty ? '0 : head.data[DATA_W-1:0];
  assign PAR_ERROR        = !empty && head.par_err;
  assign STP_ERROR        = !empty && head.stp_err;
  assign OVERRUN          = push && full && !pop;
  assign BUSY             = (state_q != IDLE);
  assign BRK_DET          = brk;
  assign state_o          = state_q;
  assign unused_head_bits = ^(head.data >> DATA_W);

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: directed scenarios plus randomized frames against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx_param;
  import uart_rx_pkg::*;

  localparam int DATA_W     = 8;
  localparam int PRESCALE_W = 6;
  localparam int FIFO_DEPTH = 4;
  localparam int W          = DATA_W + 2;

  logic                  clk = 1'b0;
  logic                  rst, rx_in, par_en, par_typ, stop2, data_ready;
  logic [PRESCALE_W-1:0] prescale;
  logic [DATA_W-1:0]     p_data;
  logic                  par_error, stp_error, data_valid, overrun, busy, brk_det;
  uart_rx_state_e        state;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int ovr_cnt = 0;
  int brk_cnt = 0;
  int valid_cyc = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  uart_rx_param #(
    .DATA_W     (DATA_W),
    .PRESCALE_W (PRESCALE_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .RX_IN      (rx_in),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .STOP2      (stop2),
    .prescale   (prescale),
    .P_DATA     (p_data),
    .PAR_ERROR  (par_error),
    .STP_ERROR  (stp_error),
    .DATA_VALID (data_valid),
    .DATA_READY (data_ready),
    .OVERRUN    (overrun),
    .BUSY       (busy),
    .BRK_DET    (brk_det),
    .state_o    (state)
  );

  // Monitor: records every accepted entry and event pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid && data_ready) got_q.push_back({p_data, par_error, stp_error});
      if (overrun)    ovr_cnt++;
      if (brk_det)    brk_cnt++;
      if (data_valid) valid_cyc++;
    end
  end

  // ---------------- reference model ----------------
  function automatic int eff_p(input logic [PRESCALE_W-1:0] ps);
    return (ps < 8) ? 8 : int'(ps);
  endfunction

  function automatic logic [W-1:0] ref_frame(input logic [DATA_W-1:0] d, input bit pen, input bit ptyp,
                                             input bit pbit, input bit s1, input bit s2en, input bit s2);
    int ones;
    bit perr, serr;
    ones = $countones(d) + int'(pbit);
    perr = pen ? (((ones % 2) == 1) != ptyp) : 1'b0;
    serr = !s1 || (s2en && !s2);
    return {d, perr, serr};
  endfunction

  function automatic bit is_break(input logic [DATA_W-1:0] d, input bit pen, input bit pbit, input bit s1);
    return (d == '0) && (!pen || !pbit) && !s1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input bit pbit, input bit s1, input bit s2,
                            input int spike_at);
    bit bits[$];
    int p;
    p = eff_p(prescale);
    bits.push_back(1'b0);
    for (int i = 0; i < DATA_W; i++) bits.push_back(d[i]);
    if (par_en) bits.push_back(pbit);
    bits.push_back(s1);
    if (stop2) bits.push_back(s2);
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c < p; c++) begin
        rx_in = bits[b] ^ ((b * p + c) == spike_at);
        @(posedge clk); #1;
      end
    end
    rx_in = 1'b1;
  endtask

  task automatic wait_got(input int n, input int budget);
    for (int i = 0; i < budget && got_q.size() < n; i++) begin @(posedge clk); #1; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; rx_in = 1'b1; par_en = 0; par_typ = 0; stop2 = 0; data_ready = 1; prescale = 8;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++; if (data_valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid got=%b exp=0", data_valid); end
    n_checks++; if (p_data !== '0)       begin n_errors++; $display("FAIL rst_data got=%h exp=0", p_data); end
    n_checks++; if (par_error !== 1'b0)  begin n_errors++; $display("FAIL rst_par got=%b exp=0", par_error); end
    n_checks++; if (stp_error !== 1'b0)  begin n_errors++; $display("FAIL rst_stp got=%b exp=0", stp_error); end
    n_checks++; if (overrun !== 1'b0)    begin n_errors++; $display("FAIL rst_ovr got=%b exp=0", overrun); end
    n_checks++; if (busy !== 1'b0)       begin n_errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    n_checks++; if (brk_det !== 1'b0)    begin n_errors++; $display("FAIL rst_brk got=%b exp=0", brk_det); end
    n_checks++; if (state !== IDLE)      begin n_errors++; $display("FAIL rst_state got=%0d exp=%0d", state, IDLE); end
    rst = 1'b0;
    idle(4);
  endtask

  task automatic test_basic();
    int base, v0;
    prescale = 8; par_en = 0; stop2 = 0; data_ready = 1;
    base = got_q.size(); v0 = valid_cyc;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, -1);
    wait_got(base + 1, 40);
    idle(4);
    n_checks++; if (got_q.size() !== base + 1) begin n_errors++; $display("FAIL basic_count got=%0d exp=%0d", got_q.size(), base + 1); end
    if (got_q.size() > base) begin
      n_checks++; if (got_q[base] !== {8'hA5, 1'b0, 1'b0}) begin n_errors++; $display("FAIL basic_entry got=%h exp=%h", got_q[base], {8'hA5, 2'b00}); end
    end
    n_checks++; if (valid_cyc - v0 !== 1) begin n_errors++; $display("FAIL basic_valid_cycles got=%0d exp=1", valid_cyc - v0); end
  endtask

  task automatic test_parity();
    int base;
    prescale = 8; par_en = 1; par_typ = 0; stop2 = 0; data_ready = 1;
    base = got_q.size();
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, -1); idle(2);
    send_frame(8'h03, 1'b0, 1'b1, 1'b1, -1); idle(2);
    par_typ = 1;
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, -1);
    wait_got(base + 3, 40);
    idle(4);
    n_checks++; if (got_q.size() !== base + 3) begin n_errors++; $display("FAIL parity_count got=%0d exp=%0d", got_q.size(), base + 3); end
    if (got_q.size() > base + 2) begin
      n_checks++; if (got_q[base] !== {8'h03, 1'b1, 1'b0})     begin n_errors++; $display("FAIL parity_even_bad got=%h exp=%h", got_q[base], {8'h03, 2'b10}); end
      n_checks++; if (got_q[base + 1] !== {8'h03, 1'b0, 1'b0}) begin n_errors++; $display("FAIL parity_even_ok got=%h exp=%h", got_q[base + 1], {8'h03, 2'b00}); end
      n_checks++; if (got_q[base + 2] !== {8'h03, 1'b0, 1'b0}) begin n_errors++; $display("FAIL parity_odd_ok got=%h exp=%h", got_q[base + 2], {8'h03, 2'b00}); end
    end
    par_en = 0; par_typ = 0;
  endtask

  task automatic test_stop2();
    int base;
    prescale = 8; par_en = 0; stop2 = 1; data_ready = 1;
    base = got_q.size();
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, -1);
    wait_got(base + 1, 40);
    idle(10);
    n_checks++; if (got_q.size() !== base + 1) begin n_errors++; $display("FAIL stop2_count got=%0d exp=%0d", got_q.size(), base + 1); end
    if (got_q.size() > base) begin
      n_checks++; if (got_q[base] !== {8'h5A, 1'b0, 1'b1}) begin n_errors++; $display("FAIL stop2_entry got=%h exp=%h", got_q[base], {8'h5A, 2'b01}); end
    end
    stop2 = 0;
  endtask

  task automatic test_glitch();
    int base;
    bit saw_busy;
    prescale = 16; data_ready = 1; saw_busy = 0;
    base = got_q.size();
    rx_in = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (busy) saw_busy = 1; end
    rx_in = 1'b1;
    repeat (40) begin @(posedge clk); #1; if (busy) saw_busy = 1; end
    n_checks++; if (saw_busy !== 1'b1)       begin n_errors++; $display("FAIL glitch_busy_seen got=%b exp=1", saw_busy); end
    n_checks++; if (busy !== 1'b0)           begin n_errors++; $display("FAIL glitch_busy_end got=%b exp=0", busy); end
    n_checks++; if (state !== IDLE)          begin n_errors++; $display("FAIL glitch_state got=%0d exp=%0d", state, IDLE); end
    n_checks++; if (got_q.size() !== base)   begin n_errors++; $display("FAIL glitch_no_push got=%0d exp=%0d", got_q.size(), base); end
    n_checks++; if (data_valid !== 1'b0)     begin n_errors++; $display("FAIL glitch_valid got=%b exp=0", data_valid); end
  endtask

  task automatic test_overrun();
    int base, o0;
    prescale = 8; par_en = 0; stop2 = 0; data_ready = 0;
    base = got_q.size(); o0 = ovr_cnt;
    for (int i = 1; i <= 5; i++) begin
      send_frame(DATA_W'(i), 1'b0, 1'b1, 1'b1, -1);
      idle(3);
    end
    idle(4);
    n_checks++; if (ovr_cnt - o0 !== 1)  begin n_errors++; $display("FAIL overrun_pulses got=%0d exp=1", ovr_cnt - o0); end
    n_checks++; if (data_valid !== 1'b1) begin n_errors++; $display("FAIL overrun_valid got=%b exp=1", data_valid); end
    data_ready = 1;
    wait_got(base + 4, 20);
    idle(4);
    n_checks++; if (got_q.size() !== base + 4) begin n_errors++; $display("FAIL overrun_drain_count got=%0d exp=%0d", got_q.size(), base + 4); end
    for (int i = 0; i < 4; i++) begin
      if (got_q.size() > base + i) begin
        n_checks++;
        if (got_q[base + i] !== {DATA_W'(i + 1), 2'b00}) begin
          n_errors++; $display("FAIL overrun_drain_%0d got=%h exp=%h", i, got_q[base + i], {DATA_W'(i + 1), 2'b00});
        end
      end
    end
    n_checks++; if (data_valid !== 1'b0) begin n_errors++; $display("FAIL overrun_empty got=%b exp=0", data_valid); end
  endtask

  task automatic test_spike();
    int base;
    prescale = 12; par_en = 0; stop2 = 0; data_ready = 1;
    base = got_q.size();
    send_frame(8'hC6, 1'b0, 1'b1, 1'b1, (1 + 2) * 12 + 6); idle(2);
    send_frame(8'hC6, 1'b0, 1'b1, 1'b1, (1 + 5) * 12 + 6);
    wait_got(base + 2, 40);
    idle(4);
    n_checks++; if (got_q.size() !== base + 2) begin n_errors++; $display("FAIL spike_count got=%0d exp=%0d", got_q.size(), base + 2); end
    if (got_q.size() > base + 1) begin
      n_checks++; if (got_q[base] !== {8'hC6, 2'b00})     begin n_errors++; $display("FAIL spike_bit2 got=%h exp=%h", got_q[base], {8'hC6, 2'b00}); end
      n_checks++; if (got_q[base + 1] !== {8'hC6, 2'b00}) begin n_errors++; $display("FAIL spike_bit5 got=%h exp=%h", got_q[base + 1], {8'hC6, 2'b00}); end
    end
  endtask

  task automatic test_rst_mid();
    int base;
    prescale = 8; par_en = 0; stop2 = 0; data_ready = 0;
    send_frame(8'h11, 1'b0, 1'b1, 1'b1, -1);
    idle(4);
    n_checks++; if (data_valid !== 1'b1) begin n_errors++; $display("FAIL rstmid_pre_valid got=%b exp=1", data_valid); end
    rx_in = 1'b0;
    repeat (3 * 8) begin @(posedge clk); #1; end
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL rstmid_busy_pre got=%b exp=1", busy); end
    rst = 1'b1; rx_in = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (data_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_valid got=%b exp=0", data_valid); end
    n_checks++; if (busy !== 1'b0)       begin n_errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    n_checks++; if (state !== IDLE)      begin n_errors++; $display("FAIL rstmid_state got=%0d exp=%0d", state, IDLE); end
    rst = 1'b0; data_ready = 1;
    idle(16);
    base = got_q.size();
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, -1);
    wait_got(base + 1, 40);
    idle(4);
    n_checks++; if (got_q.size() !== base + 1) begin n_errors++; $display("FAIL rstmid_count got=%0d exp=%0d", got_q.size(), base + 1); end
    if (got_q.size() > base) begin
      n_checks++; if (got_q[base] !== {8'h3C, 2'b00}) begin n_errors++; $display("FAIL rstmid_entry got=%h exp=%h", got_q[base], {8'h3C, 2'b00}); end
    end
  endtask

  task automatic test_break();
    int base, b0;
    prescale = 8; par_en = 0; stop2 = 0; data_ready = 1;
    base = got_q.size(); b0 = brk_cnt;
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, -1);
    idle(12);
`ifdef UART_RX_BREAK_DET_EN
    n_checks++; if (got_q.size() !== base) begin n_errors++; $display("FAIL break_no_push got=%0d exp=%0d", got_q.size(), base); end
    n_checks++; if (brk_cnt - b0 !== 1)    begin n_errors++; $display("FAIL break_pulse got=%0d exp=1", brk_cnt - b0); end
`else
    n_checks++; if (got_q.size() !== base + 1) begin n_errors++; $display("FAIL break_push got=%0d exp=%0d", got_q.size(), base + 1); end
    if (got_q.size() > base) begin
      n_checks++; if (got_q[base] !== {8'h00, 2'b01}) begin n_errors++; $display("FAIL break_entry got=%h exp=%h", got_q[base], {8'h00, 2'b01}); end
    end
    n_checks++; if (brk_cnt - b0 !== 0) begin n_errors++; $display("FAIL break_pulse got=%0d exp=0", brk_cnt - b0); end
`endif
  endtask

  task automatic test_back_to_back();
    int base, ebase, o0, nexp, p, spike;
    logic [DATA_W-1:0] d;
    bit pbit, s1, s2, last_low;
    data_ready = 1;
    base = got_q.size(); ebase = exp_q.size(); o0 = ovr_cnt;
    for (int f = 0; f < 25; f++) begin
      prescale = PRESCALE_W'($urandom_range(0, 20));
      par_en   = 1'($urandom_range(0, 1));
      par_typ  = 1'($urandom_range(0, 1));
      stop2    = 1'($urandom_range(0, 1));
      d        = DATA_W'($urandom);
      pbit     = (^d) ^ par_typ ^ ($urandom_range(0, 3) == 0);
      s1       = ($urandom_range(0, 4) != 0);
      s2       = ($urandom_range(0, 4) != 0);
      p        = eff_p(prescale);
      spike    = ($urandom_range(0, 1) == 1) ? (1 + int'($urandom_range(0, DATA_W - 1))) * p + p / 2 : -1;
`ifdef UART_RX_BREAK_DET_EN
      if (!is_break(d, par_en, pbit, s1)) exp_q.push_back(ref_frame(d, par_en, par_typ, pbit, s1, stop2, s2));
`else
      exp_q.push_back(ref_frame(d, par_en, par_typ, pbit, s1, stop2, s2));
`endif
      send_frame(d, pbit, s1, s2, spike);
      last_low = stop2 ? !s2 : !s1;
      if (last_low) idle(p);
      else          idle($urandom_range(0, 2));
    end
    idle(20);
    nexp = exp_q.size() - ebase;
    n_checks++; if (got_q.size() - base !== nexp) begin n_errors++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size() - base, nexp); end
    for (int i = 0; i < nexp; i++) begin
      if (got_q.size() > base + i) begin
        n_checks++;
        if (got_q[base + i] !== exp_q[ebase + i]) begin
          n_errors++; $display("FAIL b2b_frame_%0d got=%h exp=%h", i, got_q[base + i], exp_q[ebase + i]);
        end
      end
    end
    n_checks++; if (ovr_cnt - o0 !== 0) begin n_errors++; $display("FAIL b2b_overrun got=%0d exp=0", ovr_cnt - o0); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_stop2();
    test_glitch();
    test_overrun();
    test_spike();
    test_rst_mid();
    test_break();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
